// File: rtl/redun_mont_pkg.sv
// redun_mont_pkg: shared sizes, modulus and types for the redundant Montgomery
// datapath and its binary conversion stage.
//   NUM_WRDS  number of redundant words
//   WRD_BITS  canonical bits per word (redundant words carry one extra bit)
//   P         modulus, NUM_WRDS*WRD_BITS bits
//   redun0_t  redundant value, word i weighted 2^(i*WRD_BITS)
//   canon_t   flat canonical binary value
package redun_mont_pkg;

    localparam int unsigned NUM_WRDS = 4;
    localparam int unsigned WRD_BITS = 16;

    typedef logic [NUM_WRDS-1:0][WRD_BITS:0]   redun0_t;
    typedef logic [NUM_WRDS*WRD_BITS-1:0]      canon_t;

    localparam canon_t P = 64'hF123_4567_89AB_CDEF;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } addsub_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CARRY,
        ST_SUB,
        ST_DONE
    } r2b_state_t;

    // Word i of the modulus.
    function automatic logic [WRD_BITS-1:0] p_word(input int unsigned i);
        canon_t sh;
        sh = P >> (i * WRD_BITS);
        return sh[WRD_BITS-1:0];
    endfunction

endpackage

// File: rtl/redun_word_addsub.sv
// redun_word_addsub: one W-bit word of add or subtract with chained carry/borrow.
//   i_a, i_b  W-bit operands
//   i_ci      carry-in (add, 0..3) or borrow-in (sub, 0..1)
//   i_mode    MODE_ADD: {o_co,o_s} = a + b + ci
//             MODE_SUB: o_s = a - b - ci, o_co = {0, borrow-out}
module redun_word_addsub
    import redun_mont_pkg::*;
#(
    parameter int unsigned W = WRD_BITS
) (
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    input  logic [1:0]    i_ci,
    input  addsub_mode_t  i_mode,
    output logic [W-1:0]  o_s,
    output logic [1:0]    o_co
);

    logic [W+1:0] w_sum;
    logic [W:0]   w_dif;

    always_comb begin
        w_sum = {2'b00, i_a} + {2'b00, i_b} + {{W{1'b0}}, i_ci};
        // Borrow-in never exceeds 1 in subtract mode, so W+1 bits hold the sign.
        w_dif = {1'b0, i_a} - {1'b0, i_b} - {{(W-1){1'b0}}, i_ci};
        if (i_mode == MODE_ADD) begin
            o_s  = w_sum[W-1:0];
            o_co = w_sum[W+1:W];
        end else begin
            o_s  = w_dif[W-1:0];
            o_co = {1'b0, w_dif[W]};
        end
    end

endmodule

// File: rtl/redun_to_bin.sv
// redun_to_bin: word-serial conversion of a redundant value to canonical binary
// fully reduced mod P. One carry-propagation pass, then NUM_SUB conditional
// subtract-P passes, one word per cycle. Correct for inputs < (NUM_SUB+1)*P.
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_dat, i_val  redundant input and its valid; accepted when o_rdy
//   o_rdy         high only in IDLE
//   o_dat, o_val  canonical result, held until i_rdy
//   i_rdy         downstream accepts o_dat
module redun_to_bin
    import redun_mont_pkg::*;
#(
    parameter int unsigned NUM_SUB = 2
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  redun0_t  i_dat,
    input  logic     i_val,
    output logic     o_rdy,
    output canon_t   o_dat,
    output logic     o_val,
    input  logic     i_rdy
);

    localparam int unsigned IDX_W  = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
    localparam int unsigned PASS_W = $clog2(NUM_SUB + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WRDS - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_SUB - 1);

    r2b_state_t                         r_state, w_state_nx;
    redun0_t                            r_in;
    logic [NUM_WRDS-1:0][WRD_BITS-1:0]  r_res, r_shd, w_shd_full;
    logic [1:0]                         r_cry;
    logic [1:0]                         r_ext;   // bits above the top word
    logic                               r_bor;
    logic [IDX_W-1:0]                   r_idx;
    logic [PASS_W-1:0]                  r_pass;
    canon_t                             r_odat;
    logic                               r_oval;

    logic                               w_sub;
    logic                               w_last;
    logic [WRD_BITS-1:0]                w_a, w_b, w_s;
    logic [1:0]                         w_ci, w_co, w_cry_nx;
    logic [2:0]                         w_ext_d;

    assign w_sub  = (r_state == ST_SUB);
    assign w_last = (r_idx == LAST_IDX);
    assign w_a    = w_sub ? r_res[r_idx] : r_in[r_idx][WRD_BITS-1:0];
    assign w_b    = w_sub ? p_word(32'(r_idx)) : '0;
    assign w_ci   = w_sub ? {1'b0, r_bor} : r_cry;

    redun_word_addsub #(.W(WRD_BITS)) u_addsub (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_ci   (w_ci),
        .i_mode (w_sub ? MODE_SUB : MODE_ADD),
        .o_s    (w_s),
        .o_co   (w_co)
    );

    // The redundant extra bit of each word joins the outgoing carry.
    assign w_cry_nx = w_co + {1'b0, r_in[r_idx][WRD_BITS]};
    // Top extra bits minus the final word borrow; bit 2 set means value < P.
    assign w_ext_d  = {1'b0, r_ext} - {2'b00, w_co[0]};

    always_comb begin
        w_shd_full           = r_shd;
        w_shd_full[LAST_IDX] = w_s;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (i_val)                        w_state_nx = ST_CARRY;
            ST_CARRY: if (w_last)                       w_state_nx = ST_SUB;
            ST_SUB:   if (w_last && r_pass == LAST_PASS) w_state_nx = ST_DONE;
            ST_DONE:  if (r_oval && i_rdy)              w_state_nx = ST_IDLE;
            default:                                    w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in   <= '0;
            r_res  <= '0;
            r_shd  <= '0;
            r_cry  <= '0;
            r_ext  <= '0;
            r_bor  <= 1'b0;
            r_idx  <= '0;
            r_pass <= '0;
            r_odat <= '0;
            r_oval <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_val) begin
                        r_in   <= i_dat;
                        r_cry  <= '0;
                        r_idx  <= '0;
                        r_pass <= '0;
                        r_bor  <= 1'b0;
                    end
                end
                ST_CARRY: begin
                    r_res[r_idx] <= w_s;
                    r_cry        <= w_cry_nx;
                    r_idx        <= r_idx + 1'b1;
                    if (w_last) begin
                        r_ext <= w_cry_nx;
                        r_idx <= '0;
                        r_bor <= 1'b0;
                    end
                end
                ST_SUB: begin
                    r_shd[r_idx] <= w_s;
                    r_bor        <= w_co[0];
                    r_idx        <= r_idx + 1'b1;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_bor  <= 1'b0;
                        r_pass <= r_pass + 1'b1;
                        // Commit only when the subtraction did not go negative.
                        if (!w_ext_d[2]) begin
                            r_res <= w_shd_full;
                            r_ext <= w_ext_d[1:0];
                        end
                    end
                end
                ST_DONE: begin
                    if (!r_oval) begin
                        r_odat <= r_res;
                        r_oval <= 1'b1;
                    end else if (i_rdy) begin
                        r_oval <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rdy = (r_state == ST_IDLE);
    assign o_dat = r_odat;
    assign o_val = r_oval;

endmodule
